// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the capture-path FIFOs.
// Provides sizing math, the pointer-wrap rule and the operation encoding.
package sync_fifo_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Depth may be any value, so the pointer wraps explicitly rather than by overflow.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned size);
    return (ptr == size - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM, one clock, registered read port with synchronous clear.
// Kept standalone so a vendor block RAM can replace it.
module fifo_ram #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic                  rd_rst,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rd_data_r;

  // Write port; contents are never initialised or flushed.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port; old contents are returned on a same-address write.
  always_ff @(posedge clock) begin
    if (rd_rst) begin
      rd_data_r <= '0;
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO for the image capture data path.
// Pointers, occupancy, flags and event pulses; storage lives in fifo_ram.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned FIFO_SIZE          = 8,
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned ALMOST_FULL_LEVEL  = FIFO_SIZE - 32'd2,
  parameter int unsigned ALMOST_EMPTY_LEVEL = 32'd2,
  localparam int unsigned ADDR_WIDTH        = clog2(FIFO_SIZE),
  localparam int unsigned COUNT_WIDTH       = clog2(FIFO_SIZE + 32'd1)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   clear,
  input  logic                   push,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   pop,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [COUNT_WIDTH-1:0] data_count,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   pushed_last,
  output logic                   popped_last
);

  logic [ADDR_WIDTH-1:0]  wr_ptr_r, rd_ptr_r;
  logic [COUNT_WIDTH-1:0] data_count_r, count_next_s;
  logic                   out_valid_r, overflow_r, underflow_r;
  logic                   pushed_last_r, popped_last_r;
  logic                   full_s, empty_s, flush_s;
  logic                   push_ok_s, pop_ok_s;
  fifo_op_e               op_s;

  assign full_s  = (data_count_r == COUNT_WIDTH'(FIFO_SIZE));
  assign empty_s = (data_count_r == '0);
  assign flush_s = !reset_n || clear;

  // Acceptance decisions and next occupancy, all from the pre-edge count.
  always_comb begin
    pop_ok_s     = enable && pop && !empty_s;
    push_ok_s    = enable && push && (!full_s || pop_ok_s);
    op_s         = fifo_op_e'({push_ok_s, pop_ok_s});
    count_next_s = data_count_r;
    case (op_s)
      OP_PUSH: count_next_s = data_count_r + COUNT_WIDTH'(1);
      OP_POP:  count_next_s = data_count_r - COUNT_WIDTH'(1);
      OP_BOTH: count_next_s = data_count_r;
      OP_NONE: count_next_s = data_count_r;
      default: count_next_s = data_count_r;
    endcase
  end

  // Pointer, occupancy and pulse registers.
  always_ff @(posedge clock) begin
    if (flush_s) begin
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      data_count_r  <= '0;
      out_valid_r   <= 1'b0;
      overflow_r    <= 1'b0;
      underflow_r   <= 1'b0;
      pushed_last_r <= 1'b0;
      popped_last_r <= 1'b0;
    end else if (enable) begin
      if (push_ok_s) begin
        wr_ptr_r <= ADDR_WIDTH'(wrap_inc(32'(wr_ptr_r), FIFO_SIZE));
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ADDR_WIDTH'(wrap_inc(32'(rd_ptr_r), FIFO_SIZE));
      end
      data_count_r  <= count_next_s;
      out_valid_r   <= pop_ok_s;
      overflow_r    <= push && !push_ok_s;
      underflow_r   <= pop && !pop_ok_s;
      pushed_last_r <= (op_s == OP_PUSH) && (count_next_s == COUNT_WIDTH'(FIFO_SIZE));
      popped_last_r <= (op_s == OP_POP) && (count_next_s == '0);
    end else begin
      out_valid_r   <= 1'b0;
      overflow_r    <= 1'b0;
      underflow_r   <= 1'b0;
      pushed_last_r <= 1'b0;
      popped_last_r <= 1'b0;
    end
  end

  fifo_ram #(
    .DEPTH      (FIFO_SIZE),
    .WIDTH      (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clock   (clock),
    .wr_en   (push_ok_s && !flush_s),
    .wr_addr (wr_ptr_r),
    .wr_data (in_data),
    .rd_en   (pop_ok_s && !flush_s),
    .rd_rst  (flush_s),
    .rd_addr (rd_ptr_r),
    .rd_data (out_data)
  );

  assign out_valid    = out_valid_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;
  assign pushed_last  = pushed_last_r;
  assign popped_last  = popped_last_r;
  assign data_count   = data_count_r;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (32'(data_count_r) >= ALMOST_FULL_LEVEL);
  assign almost_empty = (32'(data_count_r) <= ALMOST_EMPTY_LEVEL);

endmodule
